kernel_conv: RTL and testbench
==============================

KERNEL_CONV -- requirements
Module: kernel_conv

Interface
REQ-001 Parameter MAX_KERNEL, default 7, is the maximum kernel edge length; it SHALL match the kernel generator's parameter.
REQ-002 Parameter PIX_W, default 8, is the pixel width in bits.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-005 Port start  input  1  is a one-cycle pulse that latches the configuration.
REQ-006 Port kernel_size  input  $clog2(MAX_KERNEL)  is the active kernel edge K.
REQ-007 Port kernel  input  [MAX_KERNEL][MAX_KERNEL][8]  holds the weights, indexed [x][y], in the same layout as the kernel generator output.
REQ-008 Port sum  input  32  is the weight total used as the normalizer.
REQ-009 Port window  input  [MAX_KERNEL][MAX_KERNEL][PIX_W]  is the pixel neighbourhood, indexed [x][y].
REQ-010 Port win_valid / win_ready  input / output  1 each  form the window handshake.
REQ-011 Port pix_out  output  PIX_W  is the filtered pixel.
REQ-012 Port pix_valid / out_ready  output / input  1 each  form the result handshake.
REQ-013 Port busy  output  1  is high in states MAC, DIV and OUT.
REQ-014 Port err_div0  output  1  is a sticky flag set when sum is 0.

Function
REQ-015 FSM states SHALL be IDLE, ACCEPT, MAC, DIV and OUT.
REQ-016 start SHALL, from any state, latch kernel, sum and K (K=0 treated as 1), clear err_div0, abort any in-flight pixel without emitting it, and go to ACCEPT next cycle.
REQ-017 win_ready SHALL be 1 only in ACCEPT.
REQ-018 On win_valid&&win_ready the window SHALL be captured, the accumulator cleared, and the FSM SHALL go to MAC.
REQ-019 MAC SHALL run one multiply-accumulate per cycle over x,y in 0..K-1, x fastest, acc += kernel[x][y]*window[x][y].
REQ-020 MAC SHALL take exactly K*K cycles and ignore entries with index >= K.
REQ-021 The accumulator SHALL be 32-bit unsigned and never overflow; the maximum is 49*255*255.
REQ-022 DIV SHALL compute q = (acc + (sum>>1)) / sum using a 32-cycle restoring divider.
REQ-023 The OUT value SHALL be pix_out = min(q, 2^PIX_W-1).
REQ-024 If latched sum == 0, DIV SHALL still take 32 cycles, pix_out SHALL be 0, and err_div0 SHALL be set.
REQ-025 In OUT, pix_valid SHALL be 1 with pix_out stable until out_ready; on the handshake edge the FSM SHALL return to ACCEPT.
REQ-026 Latency SHALL be: pix_valid rises exactly K*K+33 cycles after the window-accept edge.
REQ-027 win_valid outside ACCEPT SHALL be ignored.
REQ-028 start and win_valid in the same cycle: start SHALL win and the window SHALL NOT be captured.

Reset
REQ-029 While rst is high the FSM SHALL be in IDLE.
REQ-030 While rst is high, pix_out=0, pix_valid=0, win_ready=0, busy=0, err_div0=0, accumulator=0, and latched config=0.
REQ-031 rst SHALL override start and abort any operation mid-MAC, mid-DIV or in OUT.
REQ-032 IDLE SHALL exit only on start.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, MAX_KERNEL, PIX_W, DIV_CYCLES=32 and ACC_W=32.
REQ-034 The divider SHALL be a separate sub-module seq_divider with ports clk, rst, start, dividend[32], divisor[32], quotient[32], done, div0.
REQ-035 The x,y scan counter SHALL live inside kernel_conv.

Verification
REQ-036 Reset: assert rst 3 cycles with random inputs -> all outputs 0 and FSM in IDLE; win_ready stays 0 until start.
REQ-037 Box filter: K=3, all weights 1, sum=9, window all 90 -> pix_out=90, with pix_valid rising exactly 42 cycles after the accept edge.
REQ-038 Impulse: K=5, centre weight [2][2]=100 and all others 0, sum=100, window[2][2]=200 with the rest 7 -> pix_out=200, with latency 58.
REQ-039 Saturation and zero-sum: K=3 weights 1, sum=1, window 255 -> pix_out=255; then sum=0 -> pix_out=0 and err_div0=1, and err_div0 clears on the next start.
REQ-040 Backpressure: hold out_ready low 5 cycles -> pix_valid and pix_out stay stable, win_ready stays 0, and one result is delivered.
REQ-041 Abort: start pulse mid-MAC, then rst mid-DIV -> no pix_valid for the aborted pixels; after start the FSM is in ACCEPT, and after rst all outputs match REQ-030.

Source files
------------

// File: rtl/kernel_conv_pkg.sv
// Shared constants and FSM encoding for the kernel convolution engine.
package kernel_conv_pkg;
  localparam int MAX_KERNEL = 7;
  localparam int PIX_W      = 8;
  localparam int DIV_CYCLES = 32;
  localparam int ACC_W      = 32;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    MAC,
    DIV,
    OUT
  } state_t;
endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per cycle, DIV_CYCLES iterations after start.
module seq_divider
  import kernel_conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] dividend,
  input  logic [ACC_W-1:0] divisor,
  output logic [ACC_W-1:0] quotient,
  output logic             done,
  output logic             div0
);
  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV_CYCLES - 1);

  logic [ACC_W-1:0] rem;
  logic [ACC_W-1:0] dsr;
  logic [CW-1:0]    cnt;
  logic             running;
  logic [ACC_W:0]   rem_sh;
  logic [ACC_W:0]   diff;

  always_comb begin
    rem_sh = {rem, quotient[ACC_W-1]};
    diff   = rem_sh - {1'b0, dsr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      dsr      <= '0;
      quotient <= '0;
      cnt      <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      div0     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient <= dividend;
        rem      <= '0;
        dsr      <= divisor;
        div0     <= (divisor == '0);
        cnt      <= '0;
        running  <= 1'b1;
      end else if (running) begin
        // diff[ACC_W] is the borrow: set means the trial subtraction is restored
        rem      <= diff[ACC_W] ? rem_sh[ACC_W-1:0] : diff[ACC_W-1:0];
        quotient <= {quotient[ACC_W-2:0], ~diff[ACC_W]};
        cnt      <= cnt + CW'(1);
        if (cnt == LAST_CNT) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/kernel_conv.sv
// Weighted-window filter: serial MAC over a KxK neighbourhood, rounded
// normalisation by the weight total, saturated pixel result.
module kernel_conv
  import kernel_conv_pkg::*;
#(
  parameter int MAX_KERNEL = kernel_conv_pkg::MAX_KERNEL,
  parameter int PIX_W      = kernel_conv_pkg::PIX_W
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [$clog2(MAX_KERNEL)-1:0]                kernel_size,
  input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]   kernel,
  input  logic [31:0]                                  sum,
  input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIX_W-1:0] window,
  input  logic                                         win_valid,
  output logic                                         win_ready,
  output logic [PIX_W-1:0]                             pix_out,
  output logic                                         pix_valid,
  input  logic                                         out_ready,
  output logic                                         busy,
  output logic                                         err_div0
);
  localparam int KW = $clog2(MAX_KERNEL);
  localparam logic [ACC_W-1:0] PIX_MAX = ACC_W'(2**PIX_W - 1);

  state_t                                           state;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]       kernel_r;
  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIX_W-1:0] win_r;
  logic [31:0]                                      sum_r;
  logic [KW-1:0]                                    k_r;
  logic [KW-1:0]                                    x;
  logic [KW-1:0]                                    y;
  logic [ACC_W-1:0]                                 acc;

  logic [KW-1:0]    k_last;
  logic             mac_last;
  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] div_dividend;
  logic             div_start;
  logic [ACC_W-1:0] quotient;
  logic             div_done;
  logic             div_div0;

  // The divider is loaded on the final MAC edge with the last product folded
  // in combinationally, so no extra cycle sits between MAC and DIV.
  always_comb begin
    k_last       = k_r - KW'(1);
    mac_last     = (x == k_last) && (y == k_last);
    prod         = ACC_W'(kernel_r[x][y]) * ACC_W'(win_r[x][y]);
    div_dividend = acc + prod + (sum_r >> 1);
    div_start    = (state == MAC) && mac_last && !start;
  end

  seq_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (sum_r),
    .quotient (quotient),
    .done     (div_done),
    .div0     (div_div0)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      kernel_r  <= '0;
      win_r     <= '0;
      sum_r     <= '0;
      k_r       <= '0;
      x         <= '0;
      y         <= '0;
      acc       <= '0;
      pix_out   <= '0;
      pix_valid <= 1'b0;
      win_ready <= 1'b0;
      busy      <= 1'b0;
      err_div0  <= 1'b0;
    end else if (start) begin
      kernel_r  <= kernel;
      sum_r     <= sum;
      k_r       <= (kernel_size == '0) ? KW'(1) : kernel_size;
      err_div0  <= 1'b0;
      pix_valid <= 1'b0;
      win_ready <= 1'b1;
      busy      <= 1'b0;
      state     <= ACCEPT;
    end else begin
      case (state)
        IDLE: ;
        ACCEPT: begin
          if (win_valid) begin
            win_r     <= window;
            acc       <= '0;
            x         <= '0;
            y         <= '0;
            win_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= MAC;
          end
        end
        MAC: begin
          acc <= acc + prod;
          if (mac_last) begin
            state <= DIV;
          end else if (x == k_last) begin
            x <= '0;
            y <= y + KW'(1);
          end else begin
            x <= x + KW'(1);
          end
        end
        DIV: begin
          if (div_done) begin
            if (div_div0) begin
              pix_out  <= '0;
              err_div0 <= 1'b1;
            end else if (quotient > PIX_MAX) begin
              pix_out <= '1;
            end else begin
              pix_out <= quotient[PIX_W-1:0];
            end
            pix_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            pix_valid <= 1'b0;
            win_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ACCEPT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kernel_conv.sv
// Directed scoreboard bench for kernel_conv: stimulus pushes expected results,
// a monitor pops and checks value, error flag and latency on each result.
module tb_kernel_conv;
  import kernel_conv_pkg::*;

  localparam int MK = 7;
  localparam int PW = 8;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          start;
  logic [2:0]                    kernel_size;
  logic [MK-1:0][MK-1:0][7:0]    kernel;
  logic [31:0]                   sum;
  logic [MK-1:0][MK-1:0][PW-1:0] window;
  logic                          win_valid;
  logic                          win_ready;
  logic [PW-1:0]                 pix_out;
  logic                          pix_valid;
  logic                          out_ready;
  logic                          busy;
  logic                          err_div0;

  typedef struct {
    logic [7:0] pix;
    logic       err;
    int         acc_cyc;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int n_exp  = 0;

  kernel_conv #(.MAX_KERNEL(MK), .PIX_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .kernel_size (kernel_size),
    .kernel      (kernel),
    .sum         (sum),
    .window      (window),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .pix_out     (pix_out),
    .pix_valid   (pix_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .err_div0    (err_div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] w, input logic [7:0] p);
    for (int i = 0; i < MK; i++)
      for (int j = 0; j < MK; j++) begin
        kernel[i][j] = w;
        window[i][j] = p;
      end
  endtask

  task automatic do_start(input logic [2:0] ks, input logic [31:0] s);
    start       = 1'b1;
    kernel_size = ks;
    sum         = s;
    tick();
    start = 1'b0;
  endtask

  task automatic send_win(input int kk, input bit push, input logic [7:0] ep, input logic ee);
    int n = 0;
    win_valid = 1'b1;
    while (!win_ready && n < 100) begin
      tick();
      n++;
    end
    if (!win_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got win_ready=0 expected 1 within 100 cycles");
      win_valid = 1'b0;
    end else begin
      tick();
      win_valid = 1'b0;
      if (push) begin
        exp_q.push_back('{pix: ep, err: ee, acc_cyc: cyc, lat: kk + 33});
        n_exp++;
      end
    end
  endtask

  task automatic wait_result();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got no pix_valid expected one within 300 cycles");
      void'(exp_q.pop_front());
    end
    tick();
  endtask

  initial begin : monitor
    logic pv_q;
    exp_t e;
    pv_q = 1'b0;
    forever begin
      tick();
      if (pix_valid && !pv_q) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(pix_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pix_out", 32'(pix_out), 32'(e.pix));
          chk("err_div0", 32'(err_div0), 32'(e.err));
          chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
        end
      end
      pv_q = pix_valid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1; start = 1'b0; win_valid = 1'b0; out_ready = 1'b1;
    kernel_size = '0; sum = '0;
    fill(8'd0, 8'd0);

    for (int i = 0; i < 3; i++) begin
      start       = 1'($urandom_range(0, 1));
      win_valid   = 1'($urandom_range(0, 1));
      out_ready   = 1'($urandom_range(0, 1));
      kernel_size = 3'($urandom_range(0, 7));
      sum         = $urandom;
      for (int a = 0; a < MK; a++)
        for (int b = 0; b < MK; b++) begin
          kernel[a][b] = 8'($urandom);
          window[a][b] = 8'($urandom);
        end
      tick();
      chk("rst_pix_out", 32'(pix_out), 32'd0);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_win_ready", 32'(win_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err_div0", 32'(err_div0), 32'd0);
      chk("rst_state", 32'(dut.state), 32'(IDLE));
    end
    rst = 1'b0; start = 1'b0; win_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_win_ready", 32'(win_ready), 32'd0);
      chk("idle_state", 32'(dut.state), 32'(IDLE));
    end
    win_valid = 1'b0;

    // Box filter: (810 + 4) / 9 = 90
    fill(8'd1, 8'd90);
    do_start(3'd3, 32'd9);
    chk("accept_win_ready", 32'(win_ready), 32'd1);
    send_win(9, 1'b1, 8'd90, 1'b0);
    wait_result();

    // Impulse: (20000 + 50) / 100 = 200
    fill(8'd0, 8'd7);
    kernel[2][2] = 8'd100;
    window[2][2] = 8'd200;
    do_start(3'd5, 32'd100);
    send_win(25, 1'b1, 8'd200, 1'b0);
    wait_result();

    // Saturation: 2295 / 1 clamps to 255
    fill(8'd1, 8'd255);
    do_start(3'd3, 32'd1);
    send_win(9, 1'b1, 8'd255, 1'b0);
    wait_result();

    // Zero sum: result 0 and sticky error until the next start
    do_start(3'd3, 32'd0);
    send_win(9, 1'b1, 8'd0, 1'b1);
    wait_result();
    chk("err_sticky", 32'(err_div0), 32'd1);

    // K=0 behaves as K=1, others ignored: (150 + 1) / 2 = 75
    fill(8'd200, 8'd200);
    kernel[0][0] = 8'd3;
    window[0][0] = 8'd50;
    do_start(3'd0, 32'd2);
    chk("err_cleared", 32'(err_div0), 32'd0);
    send_win(1, 1'b1, 8'd75, 1'b0);
    wait_result();

    // Backpressure, K=2 with out-of-range entries set high: (300 + 5) / 10 = 30
    fill(8'd255, 8'd255);
    kernel[0][0] = 8'd1;  kernel[1][0] = 8'd2;  kernel[0][1] = 8'd3;  kernel[1][1] = 8'd4;
    window[0][0] = 8'd10; window[1][0] = 8'd20; window[0][1] = 8'd30; window[1][1] = 8'd40;
    do_start(3'd2, 32'd10);
    out_ready = 1'b0;
    send_win(4, 1'b1, 8'd30, 1'b0);
    begin
      int n = 0;
      while (!pix_valid && n < 100) begin
        tick();
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_pix_valid", 32'(pix_valid), 32'd1);
      chk("bp_pix_out", 32'(pix_out), 32'd30);
      chk("bp_win_ready", 32'(win_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_released_valid", 32'(pix_valid), 32'd0);
    chk("bp_released_ready", 32'(win_ready), 32'd1);

    // Abort mid-MAC with start
    fill(8'd255, 8'd255);
    do_start(3'd7, 32'd12495);
    send_win(49, 1'b0, 8'd0, 1'b0);
    repeat (10) tick();
    fill(8'd1, 8'd90);
    do_start(3'd3, 32'd9);
    chk("abort_state", 32'(dut.state), 32'(ACCEPT));
    chk("abort_win_ready", 32'(win_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);

    // start beats a simultaneous win_valid
    win_valid = 1'b1;
    do_start(3'd3, 32'd9);
    win_valid = 1'b0;
    chk("start_wins_state", 32'(dut.state), 32'(ACCEPT));
    chk("start_wins_busy", 32'(busy), 32'd0);

    // Reset mid-DIV
    send_win(9, 1'b0, 8'd0, 1'b0);
    repeat (14) tick();
    chk("mid_div_state", 32'(dut.state), 32'(DIV));
    rst = 1'b1;
    tick();
    chk("rst_abort_pix_out", 32'(pix_out), 32'd0);
    chk("rst_abort_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_abort_win_ready", 32'(win_ready), 32'd0);
    chk("rst_abort_busy", 32'(busy), 32'd0);
    chk("rst_abort_err", 32'(err_div0), 32'd0);
    chk("rst_abort_acc", dut.acc, 32'd0);
    chk("rst_abort_sum", dut.sum_r, 32'd0);
    chk("rst_abort_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    repeat (2) tick();
    chk("post_rst_win_ready", 32'(win_ready), 32'd0);

    // Full 7x7 at maximum accumulation: (3186225 + 6247) / 12495 = 255
    fill(8'd255, 8'd255);
    do_start(3'd7, 32'd12495);
    send_win(49, 1'b1, 8'd255, 1'b0);
    wait_result();

    repeat (5) tick();
    chk("outputs_delivered", 32'(n_out), 32'(n_exp));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
